// File: rtl/sha256_msg_padder.sv
// Packs 32-bit big-endian message words into 512-bit SHA-256 blocks with FIPS 180-4 padding.
// Optional feature macro SHA_PAD_BLKCNT_EN adds a per-message block counter output (blk_cnt).
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         out_valid,
    output logic [511:0] out_data,
    output logic         out_first,
`ifdef SHA_PAD_BLKCNT_EN
    output logic         out_last,
    output logic [15:0]  blk_cnt
`else
    output logic         out_last
`endif
);

    typedef enum logic {StAccum, StExtra} state_e;

    state_e             state_q;
    logic [31:0]        words_q [16];
    logic [3:0]         idx_q;
    logic [LEN_W-1:0]   len_q;
    logic               first_q;
    logic               spill_q;
    logic               out_valid_q;
    logic [511:0]       out_data_q;
    logic               out_first_q;
    logic               out_last_q;

    logic               accept;
    logic [2:0]         nbytes;
    logic [LEN_W-1:0]   len_next;
    logic [63:0]        len_ext;
    logic [63:0]        len_hold;
    logic [31:0]        last_word;
    logic [4:0]         pad_idx;
    logic               fits;
    logic               spill;
    logic               emit;
    logic [511:0]       blk;
    logic [511:0]       extra_blk;

    assign in_ready  = (state_q == StAccum);
    assign accept    = in_valid && in_ready;
    assign nbytes    = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    assign len_next  = len_q + (in_last ? LEN_W'({nbytes, 3'b000}) : LEN_W'(32));
    assign len_ext   = 64'(len_next);
    assign len_hold  = 64'(len_q);
    // Index of the word that receives the 0x80 marker; 16 means it spills into the extra block.
    assign pad_idx   = {1'b0, idx_q} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);
    assign fits      = (pad_idx <= 5'd13);
    assign spill     = (pad_idx == 5'd16);
    assign emit      = (state_q == StExtra) || (accept && (in_last || idx_q == 4'd15));

    always_comb begin
        last_word = in_data;
        if (in_last) begin
            case (nbytes)
                3'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
                3'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
                3'd3:    last_word = {in_data[31:8], 8'h80};
                default: last_word = in_data;
            endcase
        end
    end

    always_comb begin
        blk = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < {1'b0, idx_q}) begin
                blk[32*i +: 32] = words_q[i];
            end else if (5'(i) == {1'b0, idx_q}) begin
                blk[32*i +: 32] = last_word;
            end else if (in_last && 5'(i) == pad_idx) begin
                blk[32*i +: 32] = 32'h8000_0000;
            end
        end
        if (in_last && fits) begin
            blk[479:448] = len_ext[63:32];
            blk[511:480] = len_ext[31:0];
        end
    end

    assign extra_blk = {len_hold[31:0], len_hold[63:32], 416'h0,
                        (spill_q ? 32'h8000_0000 : 32'h0000_0000)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            idx_q       <= '0;
            len_q       <= '0;
            first_q     <= 1'b1;
            spill_q     <= 1'b0;
            for (int i = 0; i < 16; i++) words_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (in_last || idx_q == 4'd15) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= blk;
                            out_first_q <= first_q;
                        end
                        if (in_last && fits) begin
                            out_last_q <= 1'b1;
                            idx_q      <= '0;
                            len_q      <= '0;
                            first_q    <= 1'b1;
                            for (int i = 0; i < 16; i++) words_q[i] <= '0;
                        end else if (in_last) begin
                            out_last_q <= 1'b0;
                            first_q    <= 1'b0;
                            idx_q      <= '0;
                            len_q      <= len_next;
                            spill_q    <= spill;
                            state_q    <= StExtra;
                        end else begin
                            words_q[idx_q] <= in_data;
                            idx_q          <= idx_q + 4'd1;
                            len_q          <= len_next;
                            if (idx_q == 4'd15) begin
                                out_last_q <= 1'b0;
                                first_q    <= 1'b0;
                            end
                        end
                    end
                end
                StExtra: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= extra_blk;
                    out_first_q <= first_q;
                    out_last_q  <= 1'b1;
                    idx_q       <= '0;
                    len_q       <= '0;
                    first_q     <= 1'b1;
                    spill_q     <= 1'b0;
                    for (int i = 0; i < 16; i++) words_q[i] <= '0;
                    state_q     <= StAccum;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (emit) begin
            blk_cnt_q <= first_q ? 16'd1 : blk_cnt_q + 16'd1;
        end else if (out_valid_q && out_last_q) begin
            blk_cnt_q <= '0;
        end
    end

    assign blk_cnt = blk_cnt_q;
`else
    logic unused_emit;
    assign unused_emit = emit;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level FIPS 180-4 padding model plus literal checks.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_first;
    logic         out_last;
`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_first (out_first),
`ifdef SHA_PAD_BLKCNT_EN
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
`else
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           pulses = 0;
    logic [31:0]  msg_w [64];
    logic [511:0] exp_data [$];
    logic         exp_first [$];
    logic         exp_last [$];

    localparam logic [511:0] AbcBlk = {32'h0000_0018, 448'h0, 32'h6162_6380};

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole message as bytes, append 0x80, zero fill to 56 mod 64, 64-bit length.
    task automatic model_msg(input int nw, input int last_bytes);
        logic [7:0]   p [$];
        logic [63:0]  bits;
        logic [511:0] d;
        int           b;
        int           nb;
        int           nblk;
        b = (last_bytes == 0) ? 4 : last_bytes;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? b : 4;
            for (int k = 0; k < nb; k++) p.push_back(msg_w[w][31-8*k -: 8]);
        end
        bits = 64'(p.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int bl = 0; bl < nblk; bl++) begin
            for (int w = 0; w < 16; w++) begin
                d[32*w +: 32] = {p[64*bl+4*w], p[64*bl+4*w+1], p[64*bl+4*w+2], p[64*bl+4*w+3]};
            end
            exp_data.push_back(d);
            exp_first.push_back(bl == 0);
            exp_last.push_back(bl == nblk - 1);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the last word is accepted.
    task automatic send_msg(input int nw, input int last_bytes, output int stall);
        int guard;
        model_msg(nw, last_bytes);
        stall = 0;
        for (int w = 0; w < nw; w++) begin
            in_valid = 1'b1;
            in_data  = msg_w[w];
            in_last  = (w == nw - 1);
            in_bytes = 2'(last_bytes);
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
                stall++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            pulses++;
            if (exp_data.size() == 0) begin
                check("unexpected_block", out_valid, 0);
            end else begin
                check("blk_data", out_data, exp_data.pop_front());
                check("blk_first", out_first, exp_first.pop_front());
                check("blk_last", out_last, exp_last.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_bytes = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // "abc"
        msg_w[0] = 32'h6162_6300;
        send_msg(1, 3, st);
        check("abc_valid", out_valid, 1);
        check("abc_data", out_data, AbcBlk);
        check("abc_first", out_first, 1);
        check("abc_last", out_last, 1);
        @(negedge clk);
        check("abc_pulse", out_valid, 0);
        check("abc_hold", out_data, AbcBlk);

        // 16 full words: 0x80 spills into the extra block
        for (int i = 0; i < 16; i++) msg_w[i] = 32'h6f6c_6568 + i;
        send_msg(16, 0, st);
        check("m16_b1_valid", out_valid, 1);
        check("m16_b1_last", out_last, 0);
        check("m16_extra_ready", in_ready, 0);
        @(negedge clk);
        check("m16_b2_valid", out_valid, 1);
        check("m16_b2_data", out_data, {32'h0000_0200, 448'h0, 32'h8000_0000});
        check("m16_b2_first", out_first, 0);
        check("m16_b2_ready", in_ready, 1);

        // 14 full words: marker in word 14, length in the extra block
        for (int i = 0; i < 14; i++) msg_w[i] = 32'h1234_5678 ^ (i * 32'h0101_0101);
        send_msg(14, 0, st);
        check("m14_w14", out_data[479:448], 32'h8000_0000);
        check("m14_w15", out_data[511:480], 32'h0);
        check("m14_extra_ready", in_ready, 0);
        @(negedge clk);
        check("m14_b2_data", out_data, {32'h0000_01C0, 480'h0});

        // 13 words, last has 2 bytes
        for (int i = 0; i < 12; i++) msg_w[i] = 32'hDEAD_0000 + i;
        msg_w[12] = 32'hAABB_0000;
        send_msg(13, 2, st);
        check("m13_w12", out_data[415:384], 32'hAABB_8000);
        check("m13_w15", out_data[511:480], 32'h0000_0190);
        check("m13_first", out_first, 1);
        check("m13_last", out_last, 1);

        // Back-to-back: 16-word message then "abc" with no idle gap
        for (int i = 0; i < 16; i++) msg_w[i] = 32'hC0DE_0000 + i;
        send_msg(16, 0, st);
        msg_w[0] = 32'h6162_63FF;
        send_msg(1, 3, st);
        check("b2b_stall_cycles", st, 1);
        check("b2b_first", out_first, 1);
        check("b2b_data", out_data, AbcBlk);

        // Further padding boundaries, checked by the model only
        for (int i = 0; i < 32; i++) msg_w[i] = 32'h0F1E_2D3C + i * 32'h1111;
        send_msg(15, 0, st);
        send_msg(17, 1, st);
        send_msg(30, 3, st);
        send_msg(14, 1, st);
        send_msg(16, 3, st);
        repeat (3) @(negedge clk);

        // Reset mid-message discards the partial block
        pulses = 0;
        for (int w = 0; w < 7; w++) begin
            in_valid = 1'b1;
            in_data  = 32'h5555_0000 + w;
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_data  = 32'h7777_7777;
        in_last  = 1'b1;
        in_bytes = 2'd3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_block", pulses, 0);
        check("rst_ready", in_ready, 1);
        msg_w[0] = 32'h6162_6300;
        send_msg(1, 3, st);
        check("rst_abc_data", out_data, AbcBlk);
        check("rst_abc_first", out_first, 1);

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_data.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
